bp_pe_pipe: RTL and testbench

Pipelined, multi-lane min-sum processing element for the polar BP decoder. Each lane takes the four messages of one butterfly: left inputs la/lb and right inputs ra/rb. It produces the two updated left messages and the two updated right messages using saturating two's-complement arithmetic. The datapath is two stages deep, with valid/ready flow control on both sides, so the block can sit between the message memories and the stage scheduler. A saturation counter is provided for fixed-point width tuning.

---
 rtl/bp_pe_pipe_if.sv | 33 +++
 rtl/bp_pe_pipe.sv | 135 +++++++++++++
 tb/tb_bp_pe_pipe.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_pe_pipe_if.sv
// Butterfly message bundle for bp_pe_pipe: input beat, output beat and the
// saturation counter controls.
interface bp_pe_pipe_if #(
  parameter int WIDTH = 20,
  parameter int LANES = 4,
  parameter int CNT_W = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] la;
  logic [LANES*WIDTH-1:0] lb;
  logic [LANES*WIDTH-1:0] ra;
  logic [LANES*WIDTH-1:0] rb;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] lo_a;
  logic [LANES*WIDTH-1:0] lo_b;
  logic [LANES*WIDTH-1:0] ro_a;
  logic [LANES*WIDTH-1:0] ro_b;
  logic                   out_sat;
  logic                   sat_clr;
  logic [CNT_W-1:0]       sat_cnt;

  modport master (
    output in_valid, la, lb, ra, rb, out_ready, sat_clr,
    input  in_ready, out_valid, lo_a, lo_b, ro_a, ro_b, out_sat, sat_cnt
  );

  modport slave (
    input  in_valid, la, lb, ra, rb, out_ready, sat_clr,
    output in_ready, out_valid, lo_a, lo_b, ro_a, ro_b, out_sat, sat_cnt
  );
endinterface

// File: rtl/bp_pe_pipe.sv
// Two-stage multi-lane min-sum butterfly for the polar BP decoder, with
// saturating arithmetic and a saturating count of saturated output beats.
module bp_pe_pipe #(
  parameter int WIDTH    = 20,
  parameter int LANES    = 4,
  parameter int ALPHA_EN = 0,
  parameter int CNT_W    = 16
) (
  input logic        clk,
  input logic        rst,
  bp_pe_pipe_if.slave bus
);
  // Handshake: a beat moves on a side when valid && ready on that side.
  // in_ready = !v1 || (!v2 || out_ready); data and valid hold while stalled.
  localparam int PW = LANES * WIDTH;
  localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  // Returns {sat_flag, value}; overflow shows as a mismatch of the top two sum bits.
  function automatic logic [WIDTH:0] sat_add(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (sum[WIDTH] != sum[WIDTH-1])
      return {1'b1, sum[WIDTH] ? MIN_V : MAX_V};
    return {1'b0, sum[WIDTH-1:0]};
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    if (x == MIN_V) return MAX_V;
    return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction

  function automatic logic [WIDTH-1:0] g_fn(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] ma;
    logic [WIDTH-1:0] mb;
    logic [WIDTH-1:0] m;
    ma = mag(a);
    mb = mag(b);
    m  = (ma < mb) ? ma : mb;
    if (ALPHA_EN != 0) m = m - (m >> 2);
    return (a[WIDTH-1] ^ b[WIDTH-1]) ? (~m + WIDTH'(1)) : m;
  endfunction

  logic             r_v1, r_v2;
  logic [PW-1:0]    r_s, r_m, r_la, r_ra, r_lb, r_rb;
  logic [LANES-1:0] r_sat1;
  logic [PW-1:0]    r_lo_a, r_lo_b, r_ro_a, r_ro_b;
  logic             r_out_sat;
  logic [CNT_W-1:0] r_sat_cnt;

  logic             w_adv1, w_adv2;
  logic [PW-1:0]    w_s, w_m, w_lo_a, w_lo_b, w_ro_a, w_ro_b;
  logic [LANES-1:0] w_sat1, w_sat2;

  assign w_adv2 = !r_v2 || bus.out_ready;
  assign w_adv1 = !r_v1 || w_adv2;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [WIDTH:0] w_s_full;
    logic [WIDTH:0] w_lob_full;
    logic [WIDTH:0] w_rob_full;

    assign w_s_full = sat_add(bus.lb[k*WIDTH +: WIDTH], bus.rb[k*WIDTH +: WIDTH]);
    assign w_s[k*WIDTH +: WIDTH] = w_s_full[WIDTH-1:0];
    assign w_sat1[k] = w_s_full[WIDTH];
    assign w_m[k*WIDTH +: WIDTH] = g_fn(bus.la[k*WIDTH +: WIDTH], bus.ra[k*WIDTH +: WIDTH]);

    assign w_lo_a[k*WIDTH +: WIDTH] = g_fn(r_la[k*WIDTH +: WIDTH], r_s[k*WIDTH +: WIDTH]);
    assign w_ro_a[k*WIDTH +: WIDTH] = g_fn(r_ra[k*WIDTH +: WIDTH], r_s[k*WIDTH +: WIDTH]);
    assign w_lob_full = sat_add(r_m[k*WIDTH +: WIDTH], r_lb[k*WIDTH +: WIDTH]);
    assign w_rob_full = sat_add(r_m[k*WIDTH +: WIDTH], r_rb[k*WIDTH +: WIDTH]);
    assign w_lo_b[k*WIDTH +: WIDTH] = w_lob_full[WIDTH-1:0];
    assign w_ro_b[k*WIDTH +: WIDTH] = w_rob_full[WIDTH-1:0];
    assign w_sat2[k] = r_sat1[k] | w_lob_full[WIDTH] | w_rob_full[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_s       <= '0;
      r_m       <= '0;
      r_la      <= '0;
      r_ra      <= '0;
      r_lb      <= '0;
      r_rb      <= '0;
      r_sat1    <= '0;
      r_lo_a    <= '0;
      r_lo_b    <= '0;
      r_ro_a    <= '0;
      r_ro_b    <= '0;
      r_out_sat <= 1'b0;
      r_sat_cnt <= '0;
    end else begin
      if (w_adv1) begin
        r_v1 <= bus.in_valid;
        if (bus.in_valid) begin
          r_s    <= w_s;
          r_m    <= w_m;
          r_la   <= bus.la;
          r_ra   <= bus.ra;
          r_lb   <= bus.lb;
          r_rb   <= bus.rb;
          r_sat1 <= w_sat1;
        end
      end
      if (w_adv2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_lo_a    <= w_lo_a;
          r_lo_b    <= w_lo_b;
          r_ro_a    <= w_ro_a;
          r_ro_b    <= w_ro_b;
          r_out_sat <= |w_sat2;
        end
      end
      // Clear has priority over a same-cycle increment.
      if (bus.sat_clr)
        r_sat_cnt <= '0;
      else if (r_v2 && bus.out_ready && r_out_sat && (r_sat_cnt != {CNT_W{1'b1}}))
        r_sat_cnt <= r_sat_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = w_adv1;
  assign bus.out_valid = r_v2;
  assign bus.lo_a      = r_lo_a;
  assign bus.lo_b      = r_lo_b;
  assign bus.ro_a      = r_ro_a;
  assign bus.ro_b      = r_ro_b;
  assign bus.out_sat   = r_out_sat;
  assign bus.sat_cnt   = r_sat_cnt;
endmodule

// File: tb/tb_bp_pe_pipe.sv
// Bench for bp_pe_pipe: two 8-bit, 2-lane instances (plain and alpha-scaled)
// share one stimulus stream; a queue scoreboard checks every output beat.
module tb_bp_pe_pipe;
  localparam int W    = 8;
  localparam int L    = 2;
  localparam int CW   = 2;
  localparam int PW   = W * L;
  localparam int VW   = 4 * PW + 1;
  localparam int MAXV = 2 ** (W - 1) - 1;
  localparam int MINV = -(2 ** (W - 1));

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bp_pe_pipe_if #(.WIDTH(W), .LANES(L), .CNT_W(CW)) bus_a ();
  bp_pe_pipe_if #(.WIDTH(W), .LANES(L), .CNT_W(CW)) bus_b ();

  bp_pe_pipe #(.WIDTH(W), .LANES(L), .ALPHA_EN(0), .CNT_W(CW)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  bp_pe_pipe #(.WIDTH(W), .LANES(L), .ALPHA_EN(1), .CNT_W(CW)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  assign bus_b.in_valid  = bus_a.in_valid;
  assign bus_b.la        = bus_a.la;
  assign bus_b.lb        = bus_a.lb;
  assign bus_b.ra        = bus_a.ra;
  assign bus_b.rb        = bus_a.rb;
  assign bus_b.out_ready = bus_a.out_ready;
  assign bus_b.sat_clr   = bus_a.sat_clr;

  // scoreboard state
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] exp_q_al[$];
  int            acc_q[$];
  logic [PW-1:0] pend_la[$], pend_lb[$], pend_ra[$], pend_rb[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc   = 0;
  bit            armed = 1'b0;
  logic [CW-1:0] exp_cnt_a = '0;
  logic [CW-1:0] exp_cnt_b = '0;

  // reference model
  function automatic int clampv(input int x);
    if (x > MAXV) return MAXV;
    if (x < MINV) return MINV;
    return x;
  endfunction

  function automatic bit ovf(input int x);
    return (x > MAXV) || (x < MINV);
  endfunction

  function automatic int magv(input int x);
    if (x == MINV) return MAXV;
    return (x < 0) ? -x : x;
  endfunction

  function automatic int gm(input int a, input int b, input bit al);
    int m;
    m = (magv(a) < magv(b)) ? magv(a) : magv(b);
    if (al) m = m - (m / 4);
    return ((a < 0) != (b < 0)) ? -m : m;
  endfunction

  function automatic logic [VW-1:0] model(input logic [PW-1:0] la, input logic [PW-1:0] lb,
                                          input logic [PW-1:0] ra, input logic [PW-1:0] rb,
                                          input bit al);
    logic [PW-1:0] oa, ob, pa, pb;
    bit s;
    int a, b, c, d, sr, sv, m, xb, yb;
    s = 1'b0;
    oa = '0; ob = '0; pa = '0; pb = '0;
    for (int k = 0; k < L; k++) begin
      a  = $signed(la[k*W +: W]);
      b  = $signed(lb[k*W +: W]);
      c  = $signed(ra[k*W +: W]);
      d  = $signed(rb[k*W +: W]);
      sr = b + d;
      sv = clampv(sr);
      m  = gm(a, c, al);
      xb = m + b;
      yb = m + d;
      if (ovf(sr) || ovf(xb) || ovf(yb)) s = 1'b1;
      oa[k*W +: W] = W'(gm(a, sv, al));
      pa[k*W +: W] = W'(gm(c, sv, al));
      ob[k*W +: W] = W'(clampv(xb));
      pb[k*W +: W] = W'(clampv(yb));
    end
    return {oa, ob, pa, pb, s};
  endfunction

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // scoreboard: compare at negedge, then advance the expected state for the next edge
  always @(negedge clk) begin : mon
    logic exp_ov, exp_ir, xfer;
    if (!armed) begin
      if (rst) armed = 1'b1;
    end else begin
      exp_ov = (acc_q.size() > 0) && ((cyc - acc_q[0]) >= 2);
      exp_ir = (acc_q.size() < 2) || bus_a.out_ready;
      chk("a.out_valid", VW'(bus_a.out_valid), VW'(exp_ov));
      chk("b.out_valid", VW'(bus_b.out_valid), VW'(exp_ov));
      chk("a.in_ready",  VW'(bus_a.in_ready),  VW'(exp_ir));
      chk("b.in_ready",  VW'(bus_b.in_ready),  VW'(exp_ir));
      if (exp_ov) begin
        chk("a.beat", {bus_a.lo_a, bus_a.lo_b, bus_a.ro_a, bus_a.ro_b, bus_a.out_sat}, exp_q[0]);
        chk("b.beat", {bus_b.lo_a, bus_b.lo_b, bus_b.ro_a, bus_b.ro_b, bus_b.out_sat}, exp_q_al[0]);
      end
      chk("a.sat_cnt", VW'(bus_a.sat_cnt), VW'(exp_cnt_a));
      chk("b.sat_cnt", VW'(bus_b.sat_cnt), VW'(exp_cnt_b));
      if (rst) begin
        exp_q.delete();
        exp_q_al.delete();
        acc_q.delete();
        exp_cnt_a = '0;
        exp_cnt_b = '0;
      end else begin
        xfer = exp_ov && bus_a.out_ready;
        if (bus_a.sat_clr) begin
          exp_cnt_a = '0;
          exp_cnt_b = '0;
        end else if (xfer) begin
          if (exp_q[0][0] && exp_cnt_a != 2'd3) exp_cnt_a = exp_cnt_a + 2'd1;
          if (exp_q_al[0][0] && exp_cnt_b != 2'd3) exp_cnt_b = exp_cnt_b + 2'd1;
        end
        if (xfer) begin
          void'(exp_q.pop_front());
          void'(exp_q_al.pop_front());
          void'(acc_q.pop_front());
        end
        if (bus_a.in_valid && exp_ir) begin
          exp_q.push_back(model(bus_a.la, bus_a.lb, bus_a.ra, bus_a.rb, 1'b0));
          exp_q_al.push_back(model(bus_a.la, bus_a.lb, bus_a.ra, bus_a.rb, 1'b1));
          acc_q.push_back(cyc);
        end
      end
    end
    cyc++;
  end

  // driver tasks
  task automatic add_raw(input logic [PW-1:0] la, input logic [PW-1:0] lb,
                         input logic [PW-1:0] ra, input logic [PW-1:0] rb);
    pend_la.push_back(la);
    pend_lb.push_back(lb);
    pend_ra.push_back(ra);
    pend_rb.push_back(rb);
  endtask

  task automatic add_beat(input int la0, input int lb0, input int ra0, input int rb0,
                          input int la1, input int lb1, input int ra1, input int rb1);
    add_raw({W'(la1), W'(la0)}, {W'(lb1), W'(lb0)}, {W'(ra1), W'(ra0)}, {W'(rb1), W'(rb0)});
  endtask

  task automatic run(input int ncyc, input bit drain, input logic [31:0] stall, input int clr_at);
    for (int c = 0; c < ncyc; c++) begin
      if (drain && pend_la.size() == 0 && acc_q.size() == 0) break;
      bus_a.in_valid = (pend_la.size() > 0);
      if (pend_la.size() > 0) begin
        bus_a.la = pend_la[0];
        bus_a.lb = pend_lb[0];
        bus_a.ra = pend_ra[0];
        bus_a.rb = pend_rb[0];
      end
      bus_a.out_ready = !((c < 32) && stall[c]);
      bus_a.sat_clr   = (c == clr_at);
      @(negedge clk);
      if (bus_a.in_valid && bus_a.in_ready) begin
        void'(pend_la.pop_front());
        void'(pend_lb.pop_front());
        void'(pend_ra.pop_front());
        void'(pend_rb.pop_front());
      end
      @(posedge clk);
      #1;
    end
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    bus_a.sat_clr   = 1'b0;
    if (drain) begin
      n_vec++;
      assert (pend_la.size() == 0 && acc_q.size() == 0) else begin
        n_err++;
        $error("FAIL drain_timeout pending=%0d in_flight=%0d required=0/0",
               pend_la.size(), acc_q.size());
      end
    end
  endtask

  task automatic check_idle_after_reset(input string tag);
    chk({tag, ".a.out_valid"}, VW'(bus_a.out_valid), VW'(0));
    chk({tag, ".a.in_ready"},  VW'(bus_a.in_ready),  VW'(1));
    chk({tag, ".a.sat_cnt"},   VW'(bus_a.sat_cnt),   VW'(0));
    chk({tag, ".a.outs"}, {bus_a.lo_a, bus_a.lo_b, bus_a.ro_a, bus_a.ro_b, bus_a.out_sat}, VW'(0));
    chk({tag, ".b.out_valid"}, VW'(bus_b.out_valid), VW'(0));
    chk({tag, ".b.sat_cnt"},   VW'(bus_b.sat_cnt),   VW'(0));
    chk({tag, ".b.outs"}, {bus_b.lo_a, bus_b.lo_b, bus_b.ro_a, bus_b.ro_b, bus_b.out_sat}, VW'(0));
  endtask

  initial begin : watchdog
    #200000;
    n_err++;
    $display("FAIL watchdog elapsed=%0t limit=200000", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // directed sequence
  initial begin
    bus_a.in_valid  = 1'b0;
    bus_a.la        = '0;
    bus_a.lb        = '0;
    bus_a.ra        = '0;
    bus_a.rb        = '0;
    bus_a.out_ready = 1'b1;
    bus_a.sat_clr   = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle_after_reset("reset");

    // basic equations (lane 0 from the plan, lane 1 extra)
    add_beat(10, -3, -4, 7, 5, 6, -7, -8);
    run(12, 1'b1, 32'h0, -1);

    // positive and negative saturation
    add_beat(127, 100, -128, 100, 0, 0, 0, 0);
    run(12, 1'b1, 32'h0, -1);
    add_beat(127, -100, -128, -100, -1, 1, 0, -1);
    run(12, 1'b1, 32'h0, -1);

    // alpha-scaled magnitude
    add_beat(40, 0, -20, 0, -20, 3, 40, -3);
    run(12, 1'b1, 32'h0, -1);

    // backpressure: 10 beats, out_ready low for cycles 3..6
    for (int i = 0; i < 10; i++)
      add_raw(PW'($urandom), PW'($urandom), PW'($urandom), PW'($urandom));
    run(60, 1'b1, 32'h0000_0078, -1);

    // random backpressure
    for (int i = 0; i < 20; i++)
      add_raw(PW'($urandom), PW'($urandom), PW'($urandom), PW'($urandom));
    run(120, 1'b1, $urandom & $urandom, -1);

    // reset with two beats in flight
    for (int i = 0; i < 4; i++) add_beat(127, 100, -128, 100, 3, 4, 5, 6);
    run(2, 1'b0, 32'h0, -1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pend_la.delete();
    pend_lb.delete();
    pend_ra.delete();
    pend_rb.delete();
    check_idle_after_reset("midreset");
    run(6, 1'b0, 32'h0, -1);

    // counter: saturates at 3, then clear beats a same-cycle increment
    for (int i = 0; i < 5; i++) add_beat(127, 100, -128, 100, 127, -100, -128, -100);
    run(40, 1'b1, 32'h0, -1);
    chk("cnt_full.a", VW'(bus_a.sat_cnt), VW'(3));
    chk("cnt_full.b", VW'(bus_b.sat_cnt), VW'(3));
    add_beat(127, 100, -128, 100, 0, 0, 0, 0);
    run(12, 1'b1, 32'h0, 2);
    chk("cnt_clr.a", VW'(bus_a.sat_cnt), VW'(0));
    chk("cnt_clr.b", VW'(bus_b.sat_cnt), VW'(0));

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
